// File: rtl/acc16_seq.sv
// acc16_seq: batch accumulator behind the 16-bit adder datapath.
// Optional saturation is enabled by defining ACC16_SAT_EN.
module acc16_seq #(
  parameter int WIDTH   = 16,
  parameter int NUM_OPS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       op_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(NUM_OPS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             sticky;
  logic [7:0]       cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [WIDTH-1:0] add_s;
  logic             add_c;
  logic             accept;
  logic             last;
  logic             take;

  // Running sum plus operand; carry out of the top bit kept separately.
  assign {add_c, add_s} = {1'b0, acc} + {1'b0, data_in};

`ifdef ACC16_SAT_EN
  // Any carry clamps to all ones; a clamped value stays clamped.
  assign acc_nxt = add_c ? {WIDTH{1'b1}} : add_s;
`else
  assign acc_nxt = add_s;
`endif

  assign accept = in_valid & in_ready;
  assign last   = (cnt == LAST);
  assign take   = (state == HOLD) & out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: clear aborts only while collecting, never in HOLD.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = last ? HOLD : ACC;
        end
      end
      ACC: begin
        if (clear) begin
          state_nxt = IDLE;
        end else if (accept && last) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    in_ready  = ~clear & rst_n;
      ACC:     in_ready  = ~clear & rst_n;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Accumulator, sticky carry and beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      sticky <= 1'b0;
      cnt    <= '0;
    end else if (take) begin
      acc    <= '0;
      sticky <= 1'b0;
      cnt    <= '0;
    end else if (clear && state != HOLD) begin
      acc    <= '0;
      sticky <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      acc    <= acc_nxt;
      sticky <= sticky | add_c;
      cnt    <= cnt + 8'd1;
    end
  end

  // Result registers load only on entry to HOLD and keep the last result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept && last) begin
      sum_q  <= acc_nxt;
      cout_q <= sticky | add_c;
    end
  end

  assign sum_out  = sum_q;
  assign cout_out = cout_q;
  assign op_cnt   = cnt;

endmodule

// File: tb/tb_acc16_seq.sv
// tb_acc16_seq: directed checks for acc16_seq.
// Expected values hand-computed from the batch sums.
module tb_acc16_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [15:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sum_out;
  logic        cout_out;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  op_cnt;

  int checks = 0;
  int errors = 0;

  acc16_seq #(.WIDTH(16), .NUM_OPS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_out   (sum_out),
    .cout_out  (cout_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op_cnt    (op_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one operand and wait (bounded) until it is accepted.
  task automatic send(input logic [15:0] v);
    int n;
    in_valid = 1'b1;
    data_in  = v;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b1;
    data_in   = 16'hFFFF;
    out_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid: got %0b required 0", out_valid);
    end
    checks++;
    if (sum_out !== 16'd0) begin
      errors++;
      $display("FAIL rst_sum: got %0d required 0", sum_out);
    end
    checks++;
    if (cout_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_cout: got %0b required 0", cout_out);
    end
    checks++;
    if (op_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_cnt: got %0d required 0", op_cnt);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_ready: got %0b required 0", in_ready);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rel_in_ready: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_wrap;
    logic [15:0] v [4];
    v[0] = 16'd40000;
    v[1] = 16'd6000;
    v[2] = 16'd17380;
    v[3] = 16'd9700;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = v[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL wrap_ready%0d: got %0b required 1", i, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || sum_out !== 16'd7544 || cout_out !== 1'b1) begin
      errors++;
      $display("FAIL wrap_result: v=%0b sum=%0d c=%0b required 1 7544 1",
               out_valid, sum_out, cout_out);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || op_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap_drop: v=%0b cnt=%0d required 0 0",
               out_valid, op_cnt);
    end
    checks++;
    if (sum_out !== 16'd7544 || cout_out !== 1'b1) begin
      errors++;
      $display("FAIL wrap_keep: sum=%0d c=%0b required 7544 1",
               sum_out, cout_out);
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] v [4];
    v[0] = 16'd5654;
    v[1] = 16'd16662;
    v[2] = 16'd1;
    v[3] = 16'd2;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(v[i]);
      if (i < 3) tick();
    end
    in_valid = 1'b1;
    data_in  = 16'd7;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          sum_out !== 16'd22319 || cout_out !== 1'b0 || op_cnt !== 8'd4) begin
        errors++;
        $display("FAIL bp_hold%0d: v=%0b rdy=%0b sum=%0d c=%0b cnt=%0d required 1 0 22319 0 4",
                 i, out_valid, in_ready, sum_out, cout_out, op_cnt);
      end
      if (i < 4) tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_take_ready: got %0b required 0", in_ready);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || op_cnt !== 8'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle: v=%0b cnt=%0d rdy=%0b required 0 0 1",
               out_valid, op_cnt, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (op_cnt !== 8'd1) begin
      errors++;
      $display("FAIL bp_fifth: cnt=%0d required 1", op_cnt);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_clear;
    out_ready = 1'b0;
    send(16'd100);
    send(16'd200);
    checks++;
    if (op_cnt !== 8'd2) begin
      errors++;
      $display("FAIL clr_pre: cnt=%0d required 2", op_cnt);
    end
    clear    = 1'b1;
    in_valid = 1'b1;
    data_in  = 16'd50;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_ready: got %0b required 0", in_ready);
    end
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (op_cnt !== 8'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_post: cnt=%0d v=%0b required 0 0", op_cnt, out_valid);
    end
    for (int i = 1; i <= 4; i++) send(16'(i));
    checks++;
    if (out_valid !== 1'b1 || sum_out !== 16'd10 || cout_out !== 1'b0) begin
      errors++;
      $display("FAIL clr_batch: v=%0b sum=%0d c=%0b required 1 10 0",
               out_valid, sum_out, cout_out);
    end
  endtask

  task automatic test_clear_hold;
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || sum_out !== 16'd10 || op_cnt !== 8'd4) begin
      errors++;
      $display("FAIL hold_clear: v=%0b sum=%0d cnt=%0d required 1 10 4",
               out_valid, sum_out, op_cnt);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_take: v=%0b required 0", out_valid);
    end
  endtask

  task automatic test_saturate;
    logic [15:0] exp_sum;
`ifdef ACC16_SAT_EN
    exp_sum = 16'hFFFF;
`else
    exp_sum = 16'h0000;
`endif
    out_ready = 1'b0;
    send(16'hFFFF);
    send(16'd1);
    send(16'd0);
    send(16'd0);
    checks++;
    if (out_valid !== 1'b1 || sum_out !== exp_sum || cout_out !== 1'b1) begin
      errors++;
      $display("FAIL sat_result: v=%0b sum=%0d c=%0b required 1 %0d 1",
               out_valid, sum_out, cout_out, exp_sum);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_backpressure();
    test_clear();
    test_clear_hold();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
